fibo_bus_checker: RTL and testbench

//   Receive-side checker for the Fibonacci bus. Samples the W-bit bus driven by the Fibonacci

---
 rtl/fibo_bus_checker_if.sv | 25 ++
 rtl/fibo_bus_checker.sv | 87 ++++++++
 tb/tb_fibo_bus_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fibo_bus_checker_if.sv
// Bus bundle between the Fibonacci generator (master) and its receive-side checker (slave).
interface fibo_bus_checker_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [W-1:0]     bus;
  logic [W-1:0]     exp_val;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic             ovf;
  logic             done;
  logic             pass;

  modport master (
    output en, bus,
    input  exp_val, err, err_cnt, vec_cnt, ovf, done, pass
  );

  modport slave (
    input  en, bus,
    output exp_val, err, err_cnt, vec_cnt, ovf, done, pass
  );
endinterface

// File: rtl/fibo_bus_checker.sv
// Receive-side checker: compares each sampled bus word against 0,1,1,2,3,5,...
// Define FIBO_CHK_RESYNC_EN to continue the sequence from the observed word instead of the expected one.
module fibo_bus_checker #(
  parameter int unsigned W       = 32,
  parameter int unsigned NUM_VEC = 13,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  fibo_bus_checker_if.slave  bif
);

  typedef enum logic {CHECK, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             ovf_q, ovf_d;

  logic             mismatch;
  logic [W-1:0]     cur;
  logic [W:0]       sum;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    prev_d  = prev_q;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    vcnt_d  = vcnt_q;
    ovf_d   = ovf_q;

    // X/Z on the bus must register as a mismatch in simulation
    mismatch = (bif.bus !== exp_q);
`ifdef FIBO_CHK_RESYNC_EN
    cur = bif.bus;
`else
    cur = exp_q;
`endif
    sum = {1'b0, cur} + {1'b0, prev_q};

    if (state_q == CHECK && bif.en) begin
      err_d = mismatch;
      if (mismatch && ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
      vcnt_d = vcnt_q + 1'b1;
      prev_d = cur;
      exp_d  = sum[W-1:0];
      if (sum[W]) begin
        ovf_d   = 1'b1;
        state_d = DONE;
      end
      if (vcnt_d == CNT_W'(NUM_VEC)) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHECK;
      exp_q   <= '0;
      prev_q  <= W'(1);
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      vcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      vcnt_q  <= vcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bif.exp_val = exp_q;
  assign bif.err     = err_q;
  assign bif.err_cnt = ecnt_q;
  assign bif.vec_cnt = vcnt_q;
  assign bif.ovf     = ovf_q;
  assign bif.done    = (state_q == DONE);
  assign bif.pass    = (state_q == DONE) && (ecnt_q == '0) && !ovf_q;

endmodule

// File: tb/tb_fibo_bus_checker.sv
// Directed bench for fibo_bus_checker: a 32-bit/13-vector instance and an 8-bit/20-vector overflow instance.
module tb_fibo_bus_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fibo_bus_checker_if #(.W(32), .CNT_W(8)) bif  ();
  fibo_bus_checker_if #(.W(8),  .CNT_W(8)) bif8 ();

  fibo_bus_checker #(.W(32), .NUM_VEC(13), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  fibo_bus_checker #(.W(8), .NUM_VEC(20), .CNT_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bif (bif8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;

  logic [31:0] fib [14] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8,
                            32'd13, 32'd21, 32'd34, 32'd55, 32'd89, 32'd144, 32'd233};

  always @(negedge clk) if (bif.err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] val);
    @(negedge clk);
    bif.en  = 1'b1;
    bif.bus = val;
  endtask

  task automatic idle();
    @(negedge clk);
    bif.en   = 1'b0;
    bif8.en  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bif.en  = 1'b0;
    bif8.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    err_pulses = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_exp"}, 64'(bif.exp_val), 64'd0);
    check({tag, "_vec"}, 64'(bif.vec_cnt), 64'd0);
    check({tag, "_ecnt"}, 64'(bif.err_cnt), 64'd0);
    check({tag, "_flags"}, 64'({bif.err, bif.ovf, bif.done, bif.pass}), 64'd0);
  endtask

  initial begin
    bif.en   = 1'b0;
    bif.bus  = '0;
    bif8.en  = 1'b0;
    bif8.bus = '0;

    // Test 1: clean stream
    do_reset();
    check_reset_state("t1_rst");
    for (int i = 0; i < 13; i++) begin
      step(fib[i]);
      if (i == 12) check("t1_done_before_last", 64'(bif.done), 64'd0);
    end
    idle();
    check("t1_done", 64'(bif.done), 64'd1);
    check("t1_pass", 64'(bif.pass), 64'd1);
    check("t1_vec", 64'(bif.vec_cnt), 64'd13);
    check("t1_ecnt", 64'(bif.err_cnt), 64'd0);
    check("t1_ovf", 64'(bif.ovf), 64'd0);
    check("t1_errp", 64'(err_pulses), 64'd0);

    // Test 6: garbage after done is ignored
    for (int i = 0; i < 5; i++) step(32'hDEAD_0000 + 32'(i));
    idle();
    check("t6_vec", 64'(bif.vec_cnt), 64'd13);
    check("t6_ecnt", 64'(bif.err_cnt), 64'd0);
    check("t6_pass", 64'(bif.pass), 64'd1);
    check("t6_exp", 64'(bif.exp_val), 64'd233);
    check("t6_errp", 64'(err_pulses), 64'd0);

    // Test 2: sample 6 corrupted (5 -> 6); reset from DONE first
    do_reset();
    check_reset_state("t2_rst");
    for (int i = 0; i < 13; i++) begin
      step((i == 5) ? 32'd6 : fib[i]);
      if (i == 6) check("t2_err_latency", 64'(bif.err), 64'd1);
      if (i == 7) check("t2_err_pulse_end", 64'(bif.err), 64'd0);
    end
    idle();
    check("t2_done", 64'(bif.done), 64'd1);
    check("t2_pass", 64'(bif.pass), 64'd0);
    check("t2_vec", 64'(bif.vec_cnt), 64'd13);
`ifdef FIBO_CHK_RESYNC_EN
    // expected after 6 is 9, then 14 (vs 13), then 21 re-aligns
    check("t2_ecnt", 64'(bif.err_cnt), 64'd3);
    check("t2_errp", 64'(err_pulses), 64'd3);
`else
    check("t2_ecnt", 64'(bif.err_cnt), 64'd1);
    check("t2_errp", 64'(err_pulses), 64'd1);
`endif

    // Test 3: en low for 3 clocks after 4 samples
    do_reset();
    for (int i = 0; i < 4; i++) step(fib[i]);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("t3_exp_hold", 64'(bif.exp_val), 64'd3);
      check("t3_vec_hold", 64'(bif.vec_cnt), 64'd4);
    end
    for (int i = 4; i < 13; i++) step(fib[i]);
    idle();
    check("t3_pass", 64'(bif.pass), 64'd1);
    check("t3_vec", 64'(bif.vec_cnt), 64'd13);
    check("t3_ecnt", 64'(bif.err_cnt), 64'd0);

    // Test 5: reset mid-run after 7 samples
    do_reset();
    for (int i = 0; i < 7; i++) step(fib[i]);
    idle();
    check("t5_vec_mid", 64'(bif.vec_cnt), 64'd7);
    check("t5_exp_mid", 64'(bif.exp_val), 64'd13);
    do_reset();
    check_reset_state("t5_rst");
    for (int i = 0; i < 13; i++) step(fib[i]);
    idle();
    check("t5_pass", 64'(bif.pass), 64'd1);
    check("t5_vec", 64'(bif.vec_cnt), 64'd13);

    // Test 4: 8-bit overflow at 144+89 -> 233 ok, 233+144 = 377 overflows
    do_reset();
    check("t4_rst_exp", 64'(bif8.exp_val), 64'd0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bif8.en  = 1'b1;
      bif8.bus = fib[i][7:0];
    end
    idle();
    check("t4_done_pre", 64'(bif8.done), 64'd0);
    check("t4_ovf_pre", 64'(bif8.ovf), 64'd0);
    check("t4_exp_pre", 64'(bif8.exp_val), 64'd233);
    @(negedge clk);
    bif8.en  = 1'b1;
    bif8.bus = 8'd233;
    idle();
    check("t4_ovf", 64'(bif8.ovf), 64'd1);
    check("t4_done", 64'(bif8.done), 64'd1);
    check("t4_pass", 64'(bif8.pass), 64'd0);
    check("t4_vec", 64'(bif8.vec_cnt), 64'd14);
    check("t4_ecnt", 64'(bif8.err_cnt), 64'd0);
    check("t4_exp_wrap", 64'(bif8.exp_val), 64'd121);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
